// File: rtl/rob_commit_unit.sv
// Reorder buffer commit stage: retires completed entries in program order and
// raises a one-cycle flush when the oldest entry completed with an exception.
`ifndef PHYSICAL_REG_NUM_WIDTH
`define PHYSICAL_REG_NUM_WIDTH 6
`endif
`ifndef INST_ADDR_WIDTH
`define INST_ADDR_WIDTH 32
`endif

module rob_commit_unit #(
   parameter int ROB_DEPTH = 16,
   parameter int WB_PORTS  = 2,
   parameter int PHY_W     = `PHYSICAL_REG_NUM_WIDTH,
   localparam int TAG_W    = $clog2(ROB_DEPTH),
   localparam int ADDR_W   = `INST_ADDR_WIDTH
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      alloc_valid,
   output logic                      alloc_ready,
   input  logic                      alloc_has_dst,
   input  logic [PHY_W-1:0]          alloc_phy_rd,
   input  logic [ADDR_W-1:0]         alloc_pc,
   output logic [TAG_W-1:0]          alloc_tag,
   input  logic [WB_PORTS-1:0]       wb_valid,
   input  logic [WB_PORTS*TAG_W-1:0] wb_tag,
   input  logic [WB_PORTS-1:0]       wb_exception,
   output logic                      commit_valid,
   output logic                      commit_with_write,
   output logic [PHY_W-1:0]          commited_wr_register,
   output logic [ADDR_W-1:0]         commit_pc,
   output logic                      flush_valid,
   output logic [ADDR_W-1:0]         flush_pc,
   output logic [TAG_W:0]            count,
   output logic                      empty
);

   typedef enum logic {RUN, FLUSH} state_t;

   localparam logic [TAG_W:0]   FULL_COUNT = (TAG_W+1)'(ROB_DEPTH);
   localparam logic [TAG_W:0]   CNT_ONE    = (TAG_W+1)'(1);
   localparam logic [TAG_W-1:0] TAG_ONE    = TAG_W'(1);

   state_t            state_reg;
   logic [TAG_W-1:0]  head_reg;
   logic [TAG_W-1:0]  tail_reg;
   logic [TAG_W:0]    count_reg;

   logic [ROB_DEPTH-1:0] valid_reg;
   logic [ROB_DEPTH-1:0] done_reg;
   logic [ROB_DEPTH-1:0] exc_reg;

   logic              has_dst_mem [ROB_DEPTH];
   logic [PHY_W-1:0]  phy_rd_mem  [ROB_DEPTH];
   logic [ADDR_W-1:0] pc_mem      [ROB_DEPTH];

   logic                 head_ready;
   logic                 alloc_fire;
   logic [ROB_DEPTH-1:0] wb_hit;
   logic [ROB_DEPTH-1:0] wb_exc_hit;
   logic [ROB_DEPTH-1:0] alloc_hit;
   logic [ROB_DEPTH-1:0] commit_hit;
   logic [ROB_DEPTH-1:0] wb_take;

   assign head_ready   = (state_reg == RUN) & valid_reg[head_reg] & done_reg[head_reg];
   assign commit_valid = head_ready & ~exc_reg[head_reg];
   assign flush_valid  = head_ready & exc_reg[head_reg];

   // A full buffer stays blocked even when the head retires this cycle.
   assign alloc_ready = (count_reg < FULL_COUNT) & (state_reg == RUN) & ~flush_valid;
   assign alloc_fire  = alloc_valid & alloc_ready;
   assign alloc_tag   = tail_reg;
   assign count       = count_reg;
   assign empty       = (count_reg == '0);

   assign commit_with_write    = commit_valid & has_dst_mem[head_reg];
   assign commited_wr_register = commit_with_write ? phy_rd_mem[head_reg] : '0;
   assign commit_pc            = commit_valid ? pc_mem[head_reg] : '0;
   assign flush_pc             = flush_valid ? pc_mem[head_reg] : '0;

   // Several ports reporting the same tag merge into one completion.
   always_comb begin
      wb_hit     = '0;
      wb_exc_hit = '0;
      for (int p = 0; p < WB_PORTS; p++) begin
         if (wb_valid[p]) begin
            wb_hit[wb_tag[p*TAG_W +: TAG_W]] = 1'b1;
            if (wb_exception[p]) begin
               wb_exc_hit[wb_tag[p*TAG_W +: TAG_W]] = 1'b1;
            end
         end
      end
   end

   for (genvar gi = 0; gi < ROB_DEPTH; gi++) begin : g_entry
      assign alloc_hit[gi]  = alloc_fire & (tail_reg == TAG_W'(gi));
      assign commit_hit[gi] = commit_valid & (head_reg == TAG_W'(gi));
      // valid_reg is still 0 for the entry being allocated, so same-cycle writebacks drop out here.
      assign wb_take[gi]    = (state_reg == RUN) & valid_reg[gi] & wb_hit[gi];
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_reg <= RUN;
         head_reg  <= '0;
         tail_reg  <= '0;
         count_reg <= '0;
      end else if (flush_valid) begin
         state_reg <= FLUSH;
         head_reg  <= '0;
         tail_reg  <= '0;
         count_reg <= '0;
      end else if (state_reg == FLUSH) begin
         state_reg <= RUN;
      end else begin
         if (alloc_fire) begin
            tail_reg <= tail_reg + TAG_ONE;
         end
         if (commit_valid) begin
            head_reg <= head_reg + TAG_ONE;
         end
         case ({alloc_fire, commit_valid})
            2'b10:   count_reg <= count_reg + CNT_ONE;
            2'b01:   count_reg <= count_reg - CNT_ONE;
            default: count_reg <= count_reg;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         valid_reg <= '0;
         done_reg  <= '0;
         exc_reg   <= '0;
      end else if (flush_valid) begin
         valid_reg <= '0;
      end else begin
         for (int i = 0; i < ROB_DEPTH; i++) begin
            if (alloc_hit[i]) begin
               valid_reg[i] <= 1'b1;
               done_reg[i]  <= 1'b0;
               exc_reg[i]   <= 1'b0;
            end else begin
               if (commit_hit[i]) begin
                  valid_reg[i] <= 1'b0;
               end
               if (wb_take[i]) begin
                  done_reg[i] <= 1'b1;
                  exc_reg[i]  <= exc_reg[i] | wb_exc_hit[i];
               end
            end
         end
      end
   end

   // Payload needs no reset: it is only observed behind a set valid bit.
   always_ff @(posedge clk) begin
      if (alloc_fire) begin
         has_dst_mem[tail_reg] <= alloc_has_dst;
         phy_rd_mem[tail_reg]  <= alloc_phy_rd;
         pc_mem[tail_reg]      <= alloc_pc;
      end
   end

endmodule

// File: doc/rob_commit_unit.md
ROB_COMMIT_UNIT -- requirements
Module: rob_commit_unit

Interface
REQ-001 SHALL have parameter ROB_DEPTH, default 16, entry count (power of 2, >=2).
REQ-002 SHALL have parameter WB_PORTS, default 2, number of completion ports.
REQ-003 SHALL have parameter PHY_W, default `PHYSICAL_REG_NUM_WIDTH, physical register number width; TAG_W = log2(ROB_DEPTH) (derived).
REQ-004 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port alloc_valid  input  1  dispatch request from rename.
REQ-007 SHALL have port alloc_ready  output  1  entry available; allocation occurs when alloc_valid & alloc_ready.
REQ-008 SHALL have port alloc_has_dst  input  1  instruction writes a register.
REQ-009 SHALL have port alloc_phy_rd  input  PHY_W  destination physical register.
REQ-010 SHALL have port alloc_pc  input  `INST_ADDR_WIDTH  instruction PC.
REQ-011 SHALL have port alloc_tag  output  TAG_W  index assigned to the allocating instruction (current tail).
REQ-012 SHALL have port wb_valid  input  WB_PORTS  per-port completion strobe.
REQ-013 SHALL have port wb_tag  input  WB_PORTS*TAG_W  per-port completed tag, port p in bits [p*TAG_W +: TAG_W].
REQ-014 SHALL have port wb_exception  input  WB_PORTS  per-port exception flag.
REQ-015 SHALL have port commit_valid  output  1  head instruction retires this cycle.
REQ-016 SHALL have port commit_with_write  output  1  retiring instruction has destination.
REQ-017 SHALL have port commited_wr_register  output  PHY_W  retiring destination physical register.
REQ-018 SHALL have port commit_pc  output  `INST_ADDR_WIDTH  retiring PC.
REQ-019 SHALL have port flush_valid  output  1  exception flush strobe.
REQ-020 SHALL have port flush_pc  output  `INST_ADDR_WIDTH  PC of faulting instruction.
REQ-021 SHALL have port count  output  TAG_W+1  occupied entries; port empty  output  1  count==0.

Function
REQ-022 SHALL keep per entry: valid, done, exc, has_dst, phy_rd, pc; circular head/tail pointers wrapping ROB_DEPTH-1 -> 0.
REQ-023 SHALL implement states RUN and FLUSH; FLUSH lasts exactly one cycle, then RUN.
REQ-024 SHALL drive alloc_ready = (count < ROB_DEPTH) & state==RUN & ~flush_valid; full blocks allocation even if a commit occurs in the same cycle.
REQ-025 On allocation SHALL write entry[tail] with valid=1, done=0, exc=0, inputs captured; tail increments mod ROB_DEPTH.
REQ-026 On wb_valid[p] in RUN SHALL set done[wb_tag[p]] and OR wb_exception[p] into exc, only if entry valid; writeback to invalid entry ignored; multiple ports same tag OR-merged.
REQ-027 Writeback to a tag allocated in the same cycle SHALL be ignored (entry not yet valid).
REQ-028 commit_valid SHALL be combinational: state==RUN & entry[head].valid & done & ~exc; commit_with_write/commited_wr_register/commit_pc from entry[head], zero when commit_valid=0.
REQ-029 On commit SHALL clear entry[head].valid and increment head mod ROB_DEPTH; at most one commit per cycle; latency writeback edge -> commit_valid high next cycle.
REQ-030 count SHALL update by +alloc -commit each edge; simultaneous alloc and commit leaves count unchanged.
REQ-031 When state==RUN & head valid & done & exc: flush_valid=1, flush_pc=entry[head].pc, commit_valid=0; at that edge all valid bits cleared, head=tail=count=0, state->FLUSH.
REQ-032 In FLUSH SHALL ignore writebacks, block allocation, drive commit_valid=0 and flush_valid=0.

Reset
REQ-033 Asserting reset (low) SHALL asynchronously clear all valid bits, head=tail=count=0, state=RUN; outputs: commit_valid=0, commit_with_write=0, commited_wr_register=0, commit_pc=0, flush_valid=0, flush_pc=0, empty=1, alloc_tag=0, alloc_ready=1 once reset deasserts.
REQ-034 Reset mid-operation SHALL discard all in-flight entries with no commit or flush strobe.

Verification (ROB_DEPTH=4, WB_PORTS=2)
REQ-035 Allocate phy 5 (pc 0x0) and phy 6 (pc 0x4), writeback tag1 then tag0 -> commits in order: phy 5 then phy 6, commit_with_write=1, one per cycle.
REQ-036 Allocate 4 entries, hold alloc_valid -> alloc_ready=0, count=4; writeback tag0 -> commit next cycle, alloc_ready=1 the cycle after; 5th alloc gets tag0 (wrap).
REQ-037 Both ports writeback tags 2 and 3 same cycle after tags 0,1 done -> four consecutive commit_valid cycles, tags 0..3.
REQ-038 Allocate pc 0x10,0x14; writeback tag0 with exception -> flush_valid=1, flush_pc=0x10, no commit; next cycle alloc_ready=0 (FLUSH); then count=0, empty=1, alloc_tag=0.
REQ-039 Alloc with alloc_has_dst=0 -> commit_valid=1, commit_with_write=0, commited_wr_register=0.
REQ-040 Pull reset low with 3 entries pending -> immediately count=0, commit_valid=0; post-reset writebacks to old tags cause no commit.
